// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-serial memory controller.
// Holds the state encodings, bus widths and the I/O region tag.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int RAM_ADDRESS_WIDTH = 32;
  localparam int BYTE_WIDTH        = 8;

  // Address bits [17:16] carrying this value select the I/O region.
  localparam logic [1:0] IO_REGION_TAG = 2'b11;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_STORE = 2'd1,
    MEM_LOAD  = 2'd2
  } mem_state_e;

  // Anything other than 1 or 2 bytes is handled as a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    case (size)
      3'd1:    norm_size = 3'd1;
      3'd2:    norm_size = 3'd2;
      default: norm_size = 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [2:0] size);
    logic [2:0] m;
    m = size - 3'd1;
    return m[1:0];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits ROB stores and SLB loads into byte accesses.
// Optional macro MEM_IO_STALL_EN holds I/O-region store bytes while io_buffer_full is set.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         in_rob_save,
  input  logic [2:0]                   in_rob_size,
  input  logic [RAM_ADDRESS_WIDTH-1:0] in_rob_address,
  input  logic [DATA_WIDTH-1:0]        in_rob_data,
  output logic                         out_rob_save_done,
  input  logic                         in_slb_load,
  input  logic [2:0]                   in_slb_size,
  input  logic [RAM_ADDRESS_WIDTH-1:0] in_slb_address,
  output logic                         out_slb_load_done,
  output logic [DATA_WIDTH-1:0]        out_slb_data,
  input  logic                         in_misbranch,
  input  logic [BYTE_WIDTH-1:0]        mem_din,
  output logic [BYTE_WIDTH-1:0]        mem_dout,
  output logic [RAM_ADDRESS_WIDTH-1:0] mem_a,
  output logic                         mem_wr,
  input  logic                         io_buffer_full
);

  mem_state_e state, state_nxt;

  logic [1:0] k;
  logic [1:0] cap_idx;
  logic       cap_valid;
  logic       issue_done;

  logic                         st_pend;
  logic [2:0]                   st_size;
  logic [RAM_ADDRESS_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0]        st_data;

  logic                         ld_pend;
  logic [2:0]                   ld_size;
  logic [RAM_ADDRESS_WIDTH-1:0] ld_addr;

  logic [DATA_WIDTH-1:0] ld_buf;
  logic [DATA_WIDTH-1:0] ld_merged;
  logic [DATA_WIDTH-1:0] slb_data_q;
  logic                  save_done_q;
  logic                  load_done_q;

  logic                         store_req;
  logic                         load_req;
  logic                         st_last;
  logic                         ld_last;
  logic                         ld_issue;
  logic                         io_hold;
  logic [1:0]                   ld_idx;
  logic [RAM_ADDRESS_WIDTH-1:0] st_byte_addr;
  logic [RAM_ADDRESS_WIDTH-1:0] ld_byte_addr;
  logic [DATA_WIDTH-1:0]        st_shifted;

  assign store_req = st_pend | in_rob_save;
  assign load_req  = (ld_pend | in_slb_load) & ~in_misbranch;

  assign st_byte_addr = st_addr + RAM_ADDRESS_WIDTH'(k);
  assign st_shifted   = st_data >> {k, 3'b000};
  assign st_last      = (k == last_idx(st_size));

  // Without a valid capture pending (start, or after a rdy stall) the oldest
  // uncaptured byte is (re)issued; otherwise the next byte in sequence.
  assign ld_idx       = cap_valid ? k : cap_idx;
  assign ld_issue     = !cap_valid || !issue_done;
  assign ld_byte_addr = ld_addr + RAM_ADDRESS_WIDTH'(ld_idx);
  assign ld_last      = (cap_idx == last_idx(ld_size));
  assign ld_merged    = ld_buf | (DATA_WIDTH'(mem_din) << {cap_idx, 3'b000});

`ifdef MEM_IO_STALL_EN
  assign io_hold = (state == MEM_STORE) &&
                   (st_byte_addr[17:16] == IO_REGION_TAG) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_hold   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (store_req)
          state_nxt = MEM_STORE;
        else if (load_req)
          state_nxt = MEM_LOAD;
      end
      MEM_STORE: begin
        mem_a    = st_byte_addr;
        mem_dout = st_shifted[BYTE_WIDTH-1:0];
        mem_wr   = rdy && !io_hold;
        if (!io_hold && st_last)
          state_nxt = MEM_IDLE;
      end
      MEM_LOAD: begin
        if (ld_issue)
          mem_a = ld_byte_addr;
        if (in_misbranch || (cap_valid && ld_last))
          state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  // Everything advances only while rdy is high; a stall just invalidates the
  // in-flight read so it is fetched again on resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MEM_IDLE;
      k           <= '0;
      cap_idx     <= '0;
      cap_valid   <= 1'b0;
      issue_done  <= 1'b0;
      st_pend     <= 1'b0;
      st_size     <= '0;
      st_addr     <= '0;
      st_data     <= '0;
      ld_pend     <= 1'b0;
      ld_size     <= '0;
      ld_addr     <= '0;
      ld_buf      <= '0;
      slb_data_q  <= '0;
      save_done_q <= 1'b0;
      load_done_q <= 1'b0;
    end else if (rdy) begin
      state       <= state_nxt;
      save_done_q <= 1'b0;
      load_done_q <= 1'b0;
      case (state)
        MEM_IDLE: begin
          k          <= '0;
          cap_idx    <= '0;
          cap_valid  <= 1'b0;
          issue_done <= 1'b0;
          ld_buf     <= '0;
        end
        MEM_STORE: begin
          if (!io_hold) begin
            k <= k + 2'd1;
            if (st_last) begin
              st_pend     <= 1'b0;
              save_done_q <= 1'b1;
            end
          end
        end
        MEM_LOAD: begin
          if (!in_misbranch) begin
            if (ld_issue) begin
              cap_valid <= 1'b1;
              k         <= ld_idx + 2'd1;
              if (ld_idx == last_idx(ld_size))
                issue_done <= 1'b1;
            end else begin
              cap_valid <= 1'b0;
            end
            if (cap_valid) begin
              ld_buf  <= ld_merged;
              cap_idx <= cap_idx + 2'd1;
              if (ld_last) begin
                slb_data_q  <= ld_merged;
                load_done_q <= 1'b1;
                ld_pend     <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
      // New requests take priority over the completion clears above.
      if (in_rob_save) begin
        st_pend <= 1'b1;
        st_size <= norm_size(in_rob_size);
        st_addr <= in_rob_address;
        st_data <= in_rob_data;
      end
      if (in_misbranch) begin
        ld_pend <= 1'b0;
      end else if (in_slb_load) begin
        ld_pend <= 1'b1;
        ld_size <= norm_size(in_slb_size);
        ld_addr <= in_slb_address;
      end
    end else begin
      cap_valid <= 1'b0;
    end
  end

  assign out_rob_save_done = save_done_q & rdy;
  assign out_slb_load_done = load_done_q & rdy;
  assign out_slb_data      = slb_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide synchronous RAM model.
// Covers stores, loads, arbitration, flush, rdy stalls, wrap, reset and I/O stall.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_rob_save;
  logic [2:0]  in_rob_size;
  logic [31:0] in_rob_address;
  logic [31:0] in_rob_data;
  logic        out_rob_save_done;
  logic        in_slb_load;
  logic [2:0]  in_slb_size;
  logic [31:0] in_slb_address;
  logic        out_slb_load_done;
  logic [31:0] out_slb_data;
  logic        in_misbranch;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks;
  int failures;
  int wr_count;

  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  mem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_rob_save       (in_rob_save),
    .in_rob_size       (in_rob_size),
    .in_rob_address    (in_rob_address),
    .in_rob_data       (in_rob_data),
    .out_rob_save_done (out_rob_save_done),
    .in_slb_load       (in_slb_load),
    .in_slb_size       (in_slb_size),
    .in_slb_address    (in_slb_address),
    .out_slb_load_done (out_slb_load_done),
    .out_slb_data      (out_slb_data),
    .in_misbranch      (in_misbranch),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data for the address of cycle c appears in cycle c+1.
  always @(posedge clk) begin
    if (pre_we)
      ram[pre_a] <= pre_d;
    else if (mem_wr)
      ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr)
      wr_count <= wr_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    step();
    pre_we = 1'b0;
  endtask

  // Holds the request pulses for one cycle; returns at the start of the next cycle.
  task automatic applyStimulus(input logic st, input logic [2:0] ssz, input logic [31:0] sa,
                               input logic [31:0] sd, input logic ld, input logic [2:0] lsz,
                               input logic [31:0] la);
    in_rob_save    = st;
    in_rob_size    = ssz;
    in_rob_address = sa;
    in_rob_data    = sd;
    in_slb_load    = ld;
    in_slb_size    = lsz;
    in_slb_address = la;
    step();
    in_rob_save = 1'b0;
    in_slb_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] word;
    int          wc0;
    int          n;
    checks = 0;
    failures = 0;
    wr_count = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    rst = 1'b1; rdy = 1'b1;
    in_rob_save = 1'b0; in_rob_size = '0; in_rob_address = '0; in_rob_data = '0;
    in_slb_load = 1'b0; in_slb_size = '0; in_slb_address = '0;
    in_misbranch = 1'b0; io_buffer_full = 1'b0;

    // Reset state
    repeat (3) step();
    checkOutput("rst_wr", 32'(mem_wr), 0);
    checkOutput("rst_a", mem_a, 0);
    checkOutput("rst_dout", 32'(mem_dout), 0);
    checkOutput("rst_sdone", 32'(out_rob_save_done), 0);
    checkOutput("rst_ldone", 32'(out_slb_load_done), 0);
    checkOutput("rst_data", out_slb_data, 0);
    rst = 1'b0;
    step();

    preload(12'h200, 8'h80);
    preload(12'h201, 8'hFF);
    preload(12'h202, 8'h12);
    preload(12'h203, 8'h34);
    preload(12'h000, 8'h77);

    // SW 0x11223344 to 0x100
    word = 32'h11223344;
    applyStimulus(1'b1, 3'd4, 32'h100, word, 1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sw_wr", 32'(mem_wr), 1);
      checkOutput("sw_a", mem_a, 32'h100 + 32'(i));
      checkOutput("sw_dout", 32'(mem_dout), 32'(word[8*i +: 8]));
      checkOutput("sw_early_done", 32'(out_rob_save_done), 0);
      step();
    end
    checkOutput("sw_done", 32'(out_rob_save_done), 1);
    checkOutput("sw_bus_idle", 32'(mem_wr), 0);
    step();
    checkOutput("sw_done_pulse", 32'(out_rob_save_done), 0);
    checkOutput("sw_ram", {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}, 32'h11223344);

    // LH from 0x200
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd2, 32'h200);
    checkOutput("lh_a0", mem_a, 32'h200);
    checkOutput("lh_wr", 32'(mem_wr), 0);
    step();
    checkOutput("lh_a1", mem_a, 32'h201);
    step();
    checkOutput("lh_early_done", 32'(out_slb_load_done), 0);
    step();
    checkOutput("lh_done", 32'(out_slb_load_done), 1);
    checkOutput("lh_data", out_slb_data, 32'h0000FF80);
    step();
    checkOutput("lh_done_pulse", 32'(out_slb_load_done), 0);
    checkOutput("lh_data_hold", out_slb_data, 32'h0000FF80);

    // Illegal size 3 behaves as a word load
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd3, 32'h200);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ls3_a", mem_a, 32'h200 + 32'(i));
      step();
    end
    checkOutput("ls3_early_done", 32'(out_slb_load_done), 0);
    step();
    checkOutput("ls3_done", 32'(out_slb_load_done), 1);
    checkOutput("ls3_data", out_slb_data, 32'h3412FF80);

    // Simultaneous SH and LB: store first
    applyStimulus(1'b1, 3'd2, 32'h300, 32'h0000BEEF, 1'b1, 3'd1, 32'h100);
    checkOutput("sim_a0", mem_a, 32'h300);
    checkOutput("sim_d0", 32'(mem_dout), 32'hEF);
    checkOutput("sim_wr0", 32'(mem_wr), 1);
    step();
    checkOutput("sim_a1", mem_a, 32'h301);
    checkOutput("sim_d1", 32'(mem_dout), 32'hBE);
    step();
    checkOutput("sim_sdone", 32'(out_rob_save_done), 1);
    checkOutput("sim_idle_a", mem_a, 0);
    step();
    checkOutput("sim_ld_a", mem_a, 32'h100);
    checkOutput("sim_ld_wr", 32'(mem_wr), 0);
    step();
    checkOutput("sim_ld_early", 32'(out_slb_load_done), 0);
    step();
    checkOutput("sim_ldone", 32'(out_slb_load_done), 1);
    checkOutput("sim_ldata", out_slb_data, 32'h00000044);

    // Flush during the 2nd byte of an LW with an SB waiting
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd4, 32'h100);
    checkOutput("mb_a0", mem_a, 32'h100);
    in_rob_save = 1'b1; in_rob_size = 3'd1; in_rob_address = 32'h400; in_rob_data = 32'h5A;
    step();
    in_rob_save = 1'b0;
    checkOutput("mb_a1", mem_a, 32'h101);
    in_misbranch = 1'b1;
    step();
    in_misbranch = 1'b0;
    checkOutput("mb_idle_wr", 32'(mem_wr), 0);
    checkOutput("mb_idle_a", mem_a, 0);
    checkOutput("mb_no_ldone0", 32'(out_slb_load_done), 0);
    step();
    checkOutput("mb_sb_wr", 32'(mem_wr), 1);
    checkOutput("mb_sb_a", mem_a, 32'h400);
    checkOutput("mb_sb_d", 32'(mem_dout), 32'h5A);
    step();
    checkOutput("mb_sb_done", 32'(out_rob_save_done), 1);
    checkOutput("mb_no_ldone1", 32'(out_slb_load_done), 0);
    step();
    checkOutput("mb_no_ldone2", 32'(out_slb_load_done), 0);
    checkOutput("mb_data_hold", out_slb_data, 32'h00000044);

    // SB to the I/O region with the output buffer full
    wc0 = wr_count;
    io_buffer_full = 1'b1;
    applyStimulus(1'b1, 3'd1, 32'h00030000, 32'h41, 1'b0, 3'd0, 32'h0);
`ifdef MEM_IO_STALL_EN
    for (int i = 0; i < 5; i++) begin
      checkOutput("io_hold_wr", 32'(mem_wr), 0);
      checkOutput("io_hold_done", 32'(out_rob_save_done), 0);
      step();
    end
    io_buffer_full = 1'b0;
    #1;
`endif
    checkOutput("io_wr", 32'(mem_wr), 1);
    checkOutput("io_a", mem_a, 32'h00030000);
    checkOutput("io_d", 32'(mem_dout), 32'h41);
    step();
    io_buffer_full = 1'b0;
    checkOutput("io_done", 32'(out_rob_save_done), 1);
    checkOutput("io_wcount", 32'(wr_count - wc0), 1);

    // rdy low for 3 cycles in the middle of an SW
    wc0 = wr_count;
    applyStimulus(1'b1, 3'd4, 32'h500, 32'hA1B2C3D4, 1'b0, 3'd0, 32'h0);
    checkOutput("rdy_a0", mem_a, 32'h500);
    step();
    checkOutput("rdy_a1", mem_a, 32'h501);
    step();
    rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rdy_stall_wr", 32'(mem_wr), 0);
      checkOutput("rdy_stall_done", 32'(out_rob_save_done), 0);
      step();
    end
    rdy = 1'b1;
    #1;
    checkOutput("rdy_a2", mem_a, 32'h502);
    checkOutput("rdy_d2", 32'(mem_dout), 32'hB2);
    checkOutput("rdy_wr2", 32'(mem_wr), 1);
    step();
    checkOutput("rdy_a3", mem_a, 32'h503);
    checkOutput("rdy_early_done", 32'(out_rob_save_done), 0);
    step();
    checkOutput("rdy_done", 32'(out_rob_save_done), 1);
    checkOutput("rdy_wcount", 32'(wr_count - wc0), 4);
    checkOutput("rdy_ram", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]}, 32'hA1B2C3D4);
    step();

    // rdy low in the capture cycle of an LB: the byte must be re-read
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd1, 32'h500);
    checkOutput("lrdy_a0", mem_a, 32'h500);
    step();
    rdy = 1'b0;
    step();
    rdy = 1'b1;
    #1;
    n = 0;
    while (!out_slb_load_done && n < 10) begin
      step();
      n++;
    end
    checkOutput("lrdy_done", 32'(out_slb_load_done), 1);
    checkOutput("lrdy_data", out_slb_data, 32'h000000D4);
    step();

    // Address wrap across 0xFFFFFFFF
    applyStimulus(1'b1, 3'd2, 32'hFFFFFFFF, 32'h0000CAFE, 1'b0, 3'd0, 32'h0);
    checkOutput("wrap_a0", mem_a, 32'hFFFFFFFF);
    checkOutput("wrap_d0", 32'(mem_dout), 32'hFE);
    step();
    checkOutput("wrap_a1", mem_a, 32'h00000000);
    checkOutput("wrap_d1", 32'(mem_dout), 32'hCA);
    checkOutput("wrap_wr1", 32'(mem_wr), 1);
    step();
    checkOutput("wrap_done", 32'(out_rob_save_done), 1);

    // Reset in the middle of a store aborts it without a done pulse
    applyStimulus(1'b1, 3'd4, 32'h600, 32'h55667788, 1'b0, 3'd0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rstmid_wr", 32'(mem_wr), 0);
      checkOutput("rstmid_done", 32'(out_rob_save_done), 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
